packetparse_param: RTL and testbench
====================================

Name: packetparse_param

Overview:
- Parametrised successor to the tag's bit-serial command field parser. Sits between the command decoder and the controller.
- Consumes one demodulated bit per `bitinclk` rising edge and extracts command fields: Q, up/dn, bank, full multi-byte EBV pointer, word count and cover-coded write data.
- Checks the reader handle against the tag's own handle.
- Adds the following: parametrised widths and skip counts, true EBV accumulation with overflow detection, parallel write-data word with a strobe (no gated clock), explicit done/error status, and sticky handle-fail reporting.

Parameters:
- CMD_W, 12, width of one-hot `packettype`.
- HANDLE_W, 16, handle/RN width.
- PTR_W, 16, accumulated EBV pointer width.
- WORDS_W, 8, read word-count field width.
- WDATA_W, 16, write data width; must be ≤ HANDLE_W.
- QUERY_SKIP, 9, bits discarded after QUERY is flagged, before Q.
- QADJ_SKIP, 2, bits discarded after QUERYADJ is flagged, before up/dn.

Ports:
- `bitinclk`  in  1  bit clock; one bit per rising edge.
- `reset`  in  1  synchronous, active-high.
- `bitin`  in  1  received data bit.
- `packettype`  in  CMD_W  one-hot command. Bit assignment: 1 ACK, 2 QUERY, 3 QUERYADJ, 6 REQRN, 7 READ, 8 WRITE. All other bits mean no parse.
- `currenthandle`  in  HANDLE_W  tag handle.
- `currentrn`  in  HANDLE_W  cover-code RN for write data.
- `rx_q`  out  4  Q value.
- `rx_updn`  out  3  up/dn bits.
- `readwritebank`  out  2  memory bank.
- `readwriteptr`  out  PTR_W  word pointer.
- `ptr_ovf`  out  1  EBV exceeded PTR_W.
- `readwords`  out  WORDS_W  words to read.
- `wdata`  out  WDATA_W  decoded write word.
- `wdata_vld`  out  1  one-cycle strobe when `wdata` is complete.
- `handlematch`  out  1  registered; full handle matched.
- `handlematch_early`  out  1  combinational; high on the last-bit edge of ACK/REQRN when that bit matches, or when `handlematch` is already set.
- `matchfailed`  out  1  sticky handle mismatch.
- `parse_done`  out  1  sticky; all fields for the command consumed.
- `parse_err`  out  1  sticky; `packettype` changed mid-packet.

Behaviour:
- Reset: synchronous, active-high, on `bitinclk`. Every output and the internal state return to 0/IDLE, including when reset arrives mid-packet.
- FSM states:
  - IDLE, SKIP, QFIELD, BANK, EBV_FLAG, EBV_DATA, WORDS, WDATA, HANDLE, DONE.
  - A 6-bit bit counter is shared across states and cleared on every state change.
- IDLE:
  - `packettype` == 0 or an unsupported bit → stay in IDLE; the bit is discarded.
  - On the first edge with a supported command, latch the command and consume that bit as the first bit of its first field:
    - QUERY/QUERYADJ → SKIP.
    - READ/WRITE → BANK.
    - ACK/REQRN → HANDLE.
- SKIP: discard QUERY_SKIP (or QADJ_SKIP) bits, then QFIELD.
- QFIELD: shift in MSB first, 4 bits into `rx_q` (QUERY) or 3 bits into `rx_updn` (QUERYADJ), then DONE.
- BANK: 2 bits, MSB first, then EBV_FLAG.
- EBV_FLAG: the extension bit of each EBV byte.
  - Then EBV_DATA: 7 bits, ptr = (ptr<<7)|bit, bit by bit.
  - After the 7th bit: if the extension bit was 1 → EBV_FLAG; else → WORDS (READ) or WDATA (WRITE).
  - If any bit shifted out of PTR_W would be nonzero → `ptr_ovf`=1, sticky. The low PTR_W bits are kept.
- WORDS: WORDS_W bits, MSB first, then HANDLE.
- WDATA:
  - Bit k (k=0 is MSB) is stored as `bitin` ^ `currentrn`[HANDLE_W-1-k].
  - On the edge consuming the last bit, update `wdata` and pulse `wdata_vld` high for exactly the next cycle.
  - Then HANDLE.
- HANDLE:
  - Compare `bitin` with `currenthandle`[HANDLE_W-1-k].
  - First mismatch → `matchfailed`=1. Later bits are not compared, but are still counted.
  - After HANDLE_W bits, if no mismatch → `handlematch`=1.
  - Then DONE, with `parse_done`=1.
- DONE: ignores bits. Returns to IDLE only on the edge where `packettype` == 0, and clears all status outputs there; field outputs hold.
- Any state other than IDLE/DONE: `packettype` differs from the latched value → `parse_err`=1, go to DONE with `parse_done`=0.
- `currenthandle`/`currentrn` are sampled per bit and must be stable for the packet.

Decomposition:
- Package `packetparse_pkg`:
  - One-hot command bit indices.
  - FSM state enum.
  - EBV constants (flag position, 7 data bits).
- Sub-module `ebv_accum`: bit-serial EBV accumulator with start/bit/valid inputs and ptr/ovf/done outputs. Reused later for mask-pointer parsing.

Test Plan:
- READ: bank 01, EBV byte 0x05, words 0x02, handle == `currenthandle` 0xBEEF → bank=1, ptr=5, words=2, `handlematch`=1, `parse_done`=1.
- READ, multi-byte EBV 0x81,0x00 → ptr=0x0080. With PTR_W=8, EBV 0x83,0x00 → ptr=0x80, `ptr_ovf`=1.
- WRITE: data bits 0xABCD, `currentrn`=0x1234 → `wdata`=0xB9F9 and `wdata_vld` high for exactly 1 cycle, then handle check.
- ACK: handle 0xBEEF with bit 3 flipped → `matchfailed`=1 from that edge, `handlematch`=0, `handlematch_early`=0 on bit 15. Matching handle → `handlematch_early` high on the bit-15 edge.
- QUERY: 9 skip bits, then 1010 → `rx_q`=0xA. QUERYADJ: 2 skip bits, then 110 → `rx_updn`=3'b110.
- Reset asserted mid-EBV of a READ → next cycle all outputs are 0. `packettype` switched READ→ACK mid-packet → `parse_err`=1.

Source files
------------

// File: rtl/packetparse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : packetparse_pkg                                                  |
// | Brief   : Shared command indices, parser states and EBV constants.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package packetparse_pkg;

    // Bit positions inside the one-hot packettype vector
    localparam int unsigned c_cmd_ack      = 1;
    localparam int unsigned c_cmd_query    = 2;
    localparam int unsigned c_cmd_queryadj = 3;
    localparam int unsigned c_cmd_reqrn    = 6;
    localparam int unsigned c_cmd_read     = 7;
    localparam int unsigned c_cmd_write    = 8;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SKIP     = 4'd1,
        ST_QFIELD   = 4'd2,
        ST_BANK     = 4'd3,
        ST_EBV_FLAG = 4'd4,
        ST_EBV_DATA = 4'd5,
        ST_WORDS    = 4'd6,
        ST_WDATA    = 4'd7,
        ST_HANDLE   = 4'd8,
        ST_DONE     = 4'd9
    } state_t;

    // EBV byte: extension flag in bit 7, received first, then 7 data bits
    localparam int unsigned c_ebv_flag_pos  = 7;
    localparam int unsigned c_ebv_data_bits = 7;

endpackage
`default_nettype wire

// File: rtl/packetparse_param_ebv_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ebv_accum                                                        |
// | Brief   : Bit-serial EBV accumulator with sticky overflow flag.            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ebv_accum
    import packetparse_pkg::*;
#(
    parameter int PTR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_ovf_clr,
    input  logic             i_bit_vld,
    input  logic             i_bit,
    output logic [PTR_W-1:0] o_ptr,
    output logic             o_ovf,
    output logic             o_done
);

    localparam logic [2:0] c_last_pos = 3'(c_ebv_data_bits);

    logic [2:0]       r_pos;
    logic             r_ext;
    logic [PTR_W-1:0] r_ptr;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos <= '0;
            r_ext <= 1'b0;
            r_ptr <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (i_start) begin
                r_pos <= '0;
                r_ext <= 1'b0;
                r_ptr <= '0;
                r_ovf <= 1'b0;
            end else if (i_bit_vld) begin
                if (r_pos == 3'd0) begin
                    r_ext <= i_bit;
                    r_pos <= 3'd1;
                end else begin
                    // Whatever leaves the top of the pointer is lost; flag it if nonzero
                    r_ptr <= {r_ptr[PTR_W-2:0], i_bit};
                    if (r_ptr[PTR_W-1]) begin
                        r_ovf <= 1'b1;
                    end
                    r_pos <= (r_pos == c_last_pos) ? 3'd0 : r_pos + 3'd1;
                end
            end
        end
    end

    assign o_ptr  = r_ptr;
    assign o_ovf  = r_ovf;
    assign o_done = i_bit_vld && !i_start && (r_pos == c_last_pos) && !r_ext;

endmodule
`default_nettype wire

// File: rtl/packetparse_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : packetparse_param                                                |
// | Brief   : Bit-serial command field parser with handle check.               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module packetparse_param
    import packetparse_pkg::*;
#(
    parameter int CMD_W      = 12,
    parameter int HANDLE_W   = 16,
    parameter int PTR_W      = 16,
    parameter int WORDS_W    = 8,
    parameter int WDATA_W    = 16,
    parameter int QUERY_SKIP = 9,
    parameter int QADJ_SKIP  = 2
) (
    input  logic                bitinclk,
    input  logic                reset,
    input  logic                bitin,
    input  logic [CMD_W-1:0]    packettype,
    input  logic [HANDLE_W-1:0] currenthandle,
    input  logic [HANDLE_W-1:0] currentrn,
    output logic [3:0]          rx_q,
    output logic [2:0]          rx_updn,
    output logic [1:0]          readwritebank,
    output logic [PTR_W-1:0]    readwriteptr,
    output logic                ptr_ovf,
    output logic [WORDS_W-1:0]  readwords,
    output logic [WDATA_W-1:0]  wdata,
    output logic                wdata_vld,
    output logic                handlematch,
    output logic                handlematch_early,
    output logic                matchfailed,
    output logic                parse_done,
    output logic                parse_err
);

    localparam logic [CMD_W-1:0] c_oh_ack   = CMD_W'(1) << c_cmd_ack;
    localparam logic [CMD_W-1:0] c_oh_query = CMD_W'(1) << c_cmd_query;
    localparam logic [CMD_W-1:0] c_oh_qadj  = CMD_W'(1) << c_cmd_queryadj;
    localparam logic [CMD_W-1:0] c_oh_reqrn = CMD_W'(1) << c_cmd_reqrn;
    localparam logic [CMD_W-1:0] c_oh_read  = CMD_W'(1) << c_cmd_read;
    localparam logic [CMD_W-1:0] c_oh_write = CMD_W'(1) << c_cmd_write;

    localparam logic [5:0] c_cnt_q_last      = 6'd3;
    localparam logic [5:0] c_cnt_updn_last   = 6'd2;
    localparam logic [5:0] c_cnt_bank_last   = 6'd1;
    localparam logic [5:0] c_cnt_ebv_last    = 6'(c_ebv_data_bits - 1);
    localparam logic [5:0] c_cnt_words_last  = 6'(WORDS_W - 1);
    localparam logic [5:0] c_cnt_wdata_last  = 6'(WDATA_W - 1);
    localparam logic [5:0] c_cnt_handle_last = 6'(HANDLE_W - 1);
    localparam logic [5:0] c_cnt_qskip_last  = 6'(QUERY_SKIP - 1);
    localparam logic [5:0] c_cnt_askip_last  = 6'(QADJ_SKIP - 1);

    state_t              r_state, w_state_nxt, w_st, w_first;
    logic [5:0]          r_cnt, w_cnt, w_cnt_nxt, w_skip_last;
    logic [CMD_W-1:0]    r_cmd, w_cmd;
    logic [3:0]          r_rx_q, w_rx_q_nxt;
    logic [2:0]          r_rx_updn, w_rx_updn_nxt;
    logic [1:0]          r_bank, w_bank_nxt;
    logic [WORDS_W-1:0]  r_words, w_words_nxt;
    logic [WDATA_W-1:0]  r_wshift, w_wshift_nxt, r_wdata, w_wdata_nxt;
    logic                r_wdata_vld, w_wdata_vld_nxt;
    logic                r_hm, w_hm_nxt, r_mf, w_mf_nxt;
    logic                r_done, w_done_nxt, r_err, w_err_nxt;
    logic [HANDLE_W-1:0] w_rn_sh, w_hd_sh;
    logic                w_cmd_ok, w_cmd_err, w_consume, w_wbit, w_hbit_ok;
    logic                w_is_query, w_is_read, w_is_ack_rn;
    logic                w_ebv_start, w_ebv_vld, w_ebv_done, w_ovf_clr, w_early;

    always_ff @(posedge bitinclk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cmd       <= '0;
            r_rx_q      <= '0;
            r_rx_updn   <= '0;
            r_bank      <= '0;
            r_words     <= '0;
            r_wshift    <= '0;
            r_wdata     <= '0;
            r_wdata_vld <= 1'b0;
            r_hm        <= 1'b0;
            r_mf        <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd       <= w_cmd;
            r_rx_q      <= w_rx_q_nxt;
            r_rx_updn   <= w_rx_updn_nxt;
            r_bank      <= w_bank_nxt;
            r_words     <= w_words_nxt;
            r_wshift    <= w_wshift_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wdata_vld <= w_wdata_vld_nxt;
            r_hm        <= w_hm_nxt;
            r_mf        <= w_mf_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_cmd_ok = (packettype == c_oh_ack)   || (packettype == c_oh_query) ||
                   (packettype == c_oh_qadj)  || (packettype == c_oh_reqrn) ||
                   (packettype == c_oh_read)  || (packettype == c_oh_write);
        w_first = ST_IDLE;
        if (packettype == c_oh_query) begin
            w_first = (QUERY_SKIP == 0) ? ST_QFIELD : ST_SKIP;
        end else if (packettype == c_oh_qadj) begin
            w_first = (QADJ_SKIP == 0) ? ST_QFIELD : ST_SKIP;
        end else if ((packettype == c_oh_read) || (packettype == c_oh_write)) begin
            w_first = ST_BANK;
        end else if ((packettype == c_oh_ack) || (packettype == c_oh_reqrn)) begin
            w_first = ST_HANDLE;
        end

        // The bit that starts a packet is parsed as bit 0 of its first field
        w_st  = r_state;
        w_cnt = r_cnt;
        w_cmd = r_cmd;
        if ((r_state == ST_IDLE) && w_cmd_ok) begin
            w_st  = w_first;
            w_cnt = '0;
            w_cmd = packettype;
        end

        w_cmd_err   = (r_state != ST_IDLE) && (r_state != ST_DONE) && (packettype != r_cmd);
        w_consume   = !w_cmd_err && (w_st != ST_IDLE) && (w_st != ST_DONE);
        w_is_query  = (w_cmd == c_oh_query);
        w_is_read   = (w_cmd == c_oh_read);
        w_is_ack_rn = (w_cmd == c_oh_ack) || (w_cmd == c_oh_reqrn);
        w_skip_last = w_is_query ? c_cnt_qskip_last : c_cnt_askip_last;
        w_rn_sh     = currentrn << w_cnt;
        w_hd_sh     = currenthandle << w_cnt;
        w_wbit      = bitin ^ w_rn_sh[HANDLE_W-1];
        w_hbit_ok   = (bitin == w_hd_sh[HANDLE_W-1]);
        w_ebv_start = w_consume && (w_st == ST_BANK);
        w_ebv_vld   = w_consume && ((w_st == ST_EBV_FLAG) || (w_st == ST_EBV_DATA));

        w_state_nxt     = w_st;
        w_rx_q_nxt      = r_rx_q;
        w_rx_updn_nxt   = r_rx_updn;
        w_bank_nxt      = r_bank;
        w_words_nxt     = r_words;
        w_wshift_nxt    = r_wshift;
        w_wdata_nxt     = r_wdata;
        w_wdata_vld_nxt = 1'b0;
        w_hm_nxt        = r_hm;
        w_mf_nxt        = r_mf;
        w_done_nxt      = r_done;
        w_err_nxt       = r_err;
        w_ovf_clr       = 1'b0;

        if (w_consume) begin
            case (w_st)
                ST_SKIP: begin
                    if (w_cnt == w_skip_last) w_state_nxt = ST_QFIELD;
                end
                ST_QFIELD: begin
                    if (w_is_query) begin
                        w_rx_q_nxt = {r_rx_q[2:0], bitin};
                        if (w_cnt == c_cnt_q_last) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_rx_updn_nxt = {r_rx_updn[1:0], bitin};
                        if (w_cnt == c_cnt_updn_last) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                ST_BANK: begin
                    w_bank_nxt = {r_bank[0], bitin};
                    if (w_cnt == c_cnt_bank_last) w_state_nxt = ST_EBV_FLAG;
                end
                ST_EBV_FLAG: begin
                    w_state_nxt = ST_EBV_DATA;
                end
                ST_EBV_DATA: begin
                    if (w_cnt == c_cnt_ebv_last) begin
                        if (!w_ebv_done)    w_state_nxt = ST_EBV_FLAG;
                        else if (w_is_read) w_state_nxt = ST_WORDS;
                        else                w_state_nxt = ST_WDATA;
                    end
                end
                ST_WORDS: begin
                    w_words_nxt = (r_words << 1) | WORDS_W'(bitin);
                    if (w_cnt == c_cnt_words_last) w_state_nxt = ST_HANDLE;
                end
                ST_WDATA: begin
                    w_wshift_nxt = (r_wshift << 1) | WDATA_W'(w_wbit);
                    if (w_cnt == c_cnt_wdata_last) begin
                        w_wdata_nxt     = w_wshift_nxt;
                        w_wdata_vld_nxt = 1'b1;
                        w_state_nxt     = ST_HANDLE;
                    end
                end
                ST_HANDLE: begin
                    if (!w_hbit_ok) w_mf_nxt = 1'b1;
                    if (w_cnt == c_cnt_handle_last) begin
                        w_hm_nxt    = !r_mf && w_hbit_ok;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
                default: begin
                end
            endcase
        end else if (w_cmd_err) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_DONE;
        end else if ((r_state == ST_DONE) && (packettype == '0)) begin
            w_state_nxt = ST_IDLE;
            w_hm_nxt    = 1'b0;
            w_mf_nxt    = 1'b0;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
            w_ovf_clr   = 1'b1;
        end

        w_cnt_nxt = (w_consume && (w_state_nxt == w_st)) ? w_cnt + 6'd1 : 6'd0;
        w_early   = r_hm || (w_consume && (w_st == ST_HANDLE) && w_is_ack_rn &&
                             (w_cnt == c_cnt_handle_last) && w_hbit_ok && !r_mf);
    end

    ebv_accum #(
        .PTR_W (PTR_W)
    ) u_ebv (
        .clk       (bitinclk),
        .rst       (reset),
        .i_start   (w_ebv_start),
        .i_ovf_clr (w_ovf_clr),
        .i_bit_vld (w_ebv_vld),
        .i_bit     (bitin),
        .o_ptr     (readwriteptr),
        .o_ovf     (ptr_ovf),
        .o_done    (w_ebv_done)
    );

    assign rx_q              = r_rx_q;
    assign rx_updn           = r_rx_updn;
    assign readwritebank     = r_bank;
    assign readwords         = r_words;
    assign wdata             = r_wdata;
    assign wdata_vld         = r_wdata_vld;
    assign handlematch       = r_hm;
    assign handlematch_early = w_early;
    assign matchfailed       = r_mf;
    assign parse_done        = r_done;
    assign parse_err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_packetparse_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_packetparse_param                                             |
// | Brief   : Directed scoreboard bench for packetparse_param.                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_packetparse_param;

    logic        bitinclk = 1'b0;
    logic        reset, bitin;
    logic [11:0] packettype;
    logic [15:0] currenthandle, currentrn;

    logic [3:0]  rx_q, rx_q8;
    logic [2:0]  rx_updn, rx_updn8;
    logic [1:0]  bank, bank8;
    logic [15:0] ptr, wdata, wdata8;
    logic [7:0]  ptr8, words, words8;
    logic        ovf, ovf8, wvld, wvld8, hm, hm8, early, early8;
    logic        mf, mf8, done, done8, err, err8;

    packetparse_param dut (
        .bitinclk(bitinclk), .reset(reset), .bitin(bitin), .packettype(packettype),
        .currenthandle(currenthandle), .currentrn(currentrn), .rx_q(rx_q),
        .rx_updn(rx_updn), .readwritebank(bank), .readwriteptr(ptr), .ptr_ovf(ovf),
        .readwords(words), .wdata(wdata), .wdata_vld(wvld), .handlematch(hm),
        .handlematch_early(early), .matchfailed(mf), .parse_done(done), .parse_err(err)
    );

    packetparse_param #(.PTR_W(8)) dut8 (
        .bitinclk(bitinclk), .reset(reset), .bitin(bitin), .packettype(packettype),
        .currenthandle(currenthandle), .currentrn(currentrn), .rx_q(rx_q8),
        .rx_updn(rx_updn8), .readwritebank(bank8), .readwriteptr(ptr8), .ptr_ovf(ovf8),
        .readwords(words8), .wdata(wdata8), .wdata_vld(wvld8), .handlematch(hm8),
        .handlematch_early(early8), .matchfailed(mf8), .parse_done(done8), .parse_err(err8)
    );

    always #5 bitinclk = ~bitinclk;

    typedef struct packed {
        logic [3:0]  q;
        logic [2:0]  updn;
        logic [1:0]  bank;
        logic [15:0] ptr;
        logic [7:0]  ptr8;
        logic        ovf;
        logic        ovf8;
        logic [7:0]  words;
        logic        hm;
        logic        mf;
        logic        done;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    string       sb_tag[$];
    logic [15:0] wq[$];
    int          checks = 0;
    int          errors = 0;
    int          vld_cnt = 0;
    logic [3:0]  m_q = '0;
    logic [2:0]  m_updn = '0;
    logic [1:0]  m_bank = '0;
    logic [15:0] m_ptr = '0;
    logic [7:0]  m_ptr8 = '0;
    logic [7:0]  m_words = '0;
    logic [15:0] hv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic e_hm, input logic e_mf,
                            input logic e_done, input logic e_err,
                            input logic e_ovf, input logic e_ovf8);
        exp_t e;
        e = '{q: m_q, updn: m_updn, bank: m_bank, ptr: m_ptr, ptr8: m_ptr8, ovf: e_ovf,
              ovf8: e_ovf8, words: m_words, hm: e_hm, mf: e_mf, done: e_done, err: e_err};
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic send(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bitin = v[i];
            @(posedge bitinclk);
            #1;
        end
    endtask

    task automatic end_packet();
        packettype = '0;
        bitin      = 1'b0;
        @(posedge bitinclk);
        #1;
    endtask

    task automatic check_result();
        exp_t  e;
        string t;
        e = sb.pop_front();
        t = sb_tag.pop_front();
        for (int i = 0; i < 8; i++) begin
            if (done || err) break;
            @(posedge bitinclk);
            #1;
        end
        chk({t, "_complete"}, {31'd0, done | err}, 32'd1);
        chk({t, "_q"},     {28'd0, rx_q},    {28'd0, e.q});
        chk({t, "_updn"},  {29'd0, rx_updn}, {29'd0, e.updn});
        chk({t, "_bank"},  {30'd0, bank},    {30'd0, e.bank});
        chk({t, "_ptr"},   {16'd0, ptr},     {16'd0, e.ptr});
        chk({t, "_ptr8"},  {24'd0, ptr8},    {24'd0, e.ptr8});
        chk({t, "_ovf"},   {30'd0, ovf, ovf8}, {30'd0, e.ovf, e.ovf8});
        chk({t, "_words"}, {24'd0, words},   {24'd0, e.words});
        chk({t, "_status"}, {28'd0, hm, mf, done, err}, {28'd0, e.hm, e.mf, e.done, e.err});
    endtask

    task automatic zero_check(input string t);
        chk({t, "_qub"},    {23'd0, rx_q, rx_updn, bank}, 32'd0);
        chk({t, "_ptrw"},   {8'd0, ptr, words}, 32'd0);
        chk({t, "_wdata"},  {15'd0, wdata, wvld}, 32'd0);
        chk({t, "_status"}, {26'd0, ovf, hm, early, mf, done, err}, 32'd0);
        chk({t, "_dut8a"},  {6'd0, ptr8, ovf8, rx_q8, rx_updn8, bank8, words8}, 32'd0);
        chk({t, "_dut8b"},  {10'd0, wdata8, wvld8, hm8, early8, mf8, done8, err8}, 32'd0);
    endtask

    always @(negedge bitinclk) begin
        if (wvld === 1'b1) begin
            vld_cnt++;
            if (wq.size() > 0) chk("wdata_strobe", {16'd0, wdata}, {16'd0, wq.pop_front()});
            else               chk("wdata_vld_spurious", {31'd0, wvld}, 32'd0);
        end
    end

    initial begin
        reset = 1'b1; packettype = '0; bitin = 1'b0;
        currenthandle = 16'hBEEF; currentrn = 16'h1234;
        repeat (2) @(posedge bitinclk);
        #1;
        zero_check("reset");
        reset = 1'b0;

        // READ, single-byte EBV
        m_bank = 2'd1; m_ptr = 16'h0005; m_ptr8 = 8'h05; m_words = 8'h02;
        push_exp("read1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        packettype = 12'h080;
        send({2'b01, 8'h05, 8'h02, 16'hBEEF}, 34);
        check_result();
        end_packet();
        chk("read1_clr", {30'd0, done, hm}, 32'd0);
        chk("read1_hold_ptr", {16'd0, ptr}, 32'h5);

        // READ, two-byte EBV
        m_bank = 2'd0; m_ptr = 16'h0080; m_ptr8 = 8'h80; m_words = 8'h01;
        push_exp("read_ebv2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        packettype = 12'h080;
        send({2'b00, 8'h81, 8'h00, 8'h01, 16'hBEEF}, 42);
        check_result();
        end_packet();

        // READ, EBV overflowing the 8-bit pointer instance
        m_bank = 2'd2; m_ptr = 16'h0180; m_ptr8 = 8'h80; m_words = 8'h03;
        push_exp("read_ovf", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        packettype = 12'h080;
        send({2'b10, 8'h83, 8'h00, 8'h03, 16'hBEEF}, 42);
        check_result();
        end_packet();
        chk("ovf8_cleared", {31'd0, ovf8}, 32'd0);
        chk("ptr8_held", {24'd0, ptr8}, 32'h80);

        // WRITE with cover-coded data
        vld_cnt = 0;
        wq.push_back(16'hB9F9);
        m_bank = 2'd3; m_ptr = 16'h0000; m_ptr8 = 8'h00;
        push_exp("write", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        packettype = 12'h100;
        send({2'b11, 8'h00, 16'hABCD, 16'hBEEF}, 42);
        check_result();
        chk("wdata_vld_pulses", vld_cnt, 32'd1);
        chk("wdata_value", {16'd0, wdata}, 32'hB9F9);
        chk("wdata_sb_drained", wq.size(), 32'd0);
        end_packet();

        // ACK with value bit 3 of the handle flipped
        push_exp("ack_bad", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        packettype = 12'h002;
        hv = 16'hBEEF ^ 16'h0008;
        for (int i = 15; i >= 0; i--) begin
            bitin = hv[i];
            if (i == 0) chk("ack_bad_early_last", {31'd0, early}, 32'd0);
            @(posedge bitinclk);
            #1;
            if (i == 4) chk("ack_bad_mf_before", {31'd0, mf}, 32'd0);
            if (i == 3) chk("ack_bad_mf_at_bit", {31'd0, mf}, 32'd1);
        end
        check_result();
        end_packet();

        // ACK with matching handle
        push_exp("ack_ok", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        packettype = 12'h002;
        hv = 16'hBEEF;
        for (int i = 15; i >= 0; i--) begin
            bitin = hv[i];
            if (i == 1) chk("ack_ok_early_bit14", {31'd0, early}, 32'd0);
            if (i == 0) chk("ack_ok_early_bit15", {31'd0, early}, 32'd1);
            @(posedge bitinclk);
            #1;
        end
        check_result();
        chk("ack_ok_early_held", {31'd0, early}, 32'd1);
        end_packet();

        // QUERY then QUERYADJ
        m_q = 4'hA;
        push_exp("query", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        packettype = 12'h004;
        send({9'h155, 4'hA}, 13);
        check_result();
        end_packet();
        m_updn = 3'b110;
        push_exp("qadj", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        packettype = 12'h008;
        send({2'b11, 3'b110}, 5);
        check_result();
        end_packet();

        // Unsupported command is ignored
        packettype = 12'h010;
        send(64'hF, 4);
        chk("unsup_status", {30'd0, done, err}, 32'd0);
        end_packet();

        // packettype switched mid-packet
        m_bank = 2'd1;
        push_exp("perr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        packettype = 12'h080;
        send(64'h1, 2);
        packettype = 12'h002;
        send(64'h1, 1);
        check_result();
        end_packet();
        chk("perr_cleared", {31'd0, err}, 32'd0);

        // Reset in the middle of an EBV
        packettype = 12'h080;
        send({2'b10, 1'b1, 3'b101}, 6);
        reset = 1'b1;
        packettype = '0;
        @(posedge bitinclk);
        #1;
        zero_check("midrst");
        reset = 1'b0;

        // REQRN after reset parses from clean state
        m_q = '0; m_updn = '0; m_bank = '0; m_ptr = '0; m_ptr8 = '0; m_words = '0;
        push_exp("reqrn", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        packettype = 12'h040;
        send(64'hBEEF, 16);
        check_result();
        end_packet();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
